// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a 2-input logic gate: applies the four input
// vectors in order, compares the gate output to a latched truth table, reports result.
module gate_bist_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] truth,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] first_fail,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] settle_cnt;
  logic [3:0] truth_q;
  logic       mismatch;
  logic [2:0] err_next;

  assign mismatch = (dut_out != truth_q[idx]);
  // Four vectors can never exceed 4 mismatches, but the count is still clamped.
  assign err_next = (err_cnt == 3'd4) ? 3'd4 : err_cnt + 3'd1;

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order inside this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      truth_q    <= 4'd0;
      dut_in1    <= 1'b0;
      dut_in2    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= 3'd0;
      first_fail <= 2'd0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= APPLY;
            truth_q    <= truth;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            {dut_in1, dut_in2} <= 2'b00;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= 3'd0;
            first_fail <= 2'd0;
            fail_valid <= 1'b0;
          end
        end

        APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= SAMPLE;
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        SAMPLE: begin
          if (mismatch) begin
            err_cnt <= err_next;
            if (!fail_valid) begin
              first_fail <= idx;
              fail_valid <= 1'b1;
            end
          end
          if (idx == 2'd3) begin
            state <= DONE;
            {dut_in1, dut_in2} <= 2'b00;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt == 3'd0) && !mismatch;
          end else begin
            state <= APPLY;
            idx   <= idx + 2'd1;
            {dut_in1, dut_in2} <= idx + 2'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: two instances (SETTLE=2 and SETTLE=1)
// driving a table-defined gate model, checked cycle by cycle against a run model.
module tb_gate_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] truth = 4'd0;
  logic [3:0] gate_tbl = 4'd0;

  logic       start0, dut_out0, in1_0, in2_0, busy0, done0, pass0, fv0;
  logic [2:0] err0;
  logic [1:0] ff0;
  logic       start1, dut_out1, in1_1, in2_1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] ff1;
  logic [10:0] obs0, obs1, obs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign start0   = start & ~sel;
  assign start1   = start & sel;
  assign dut_out0 = gate_tbl[{in1_0, in2_0}];
  assign dut_out1 = gate_tbl[{in1_1, in2_1}];
  assign obs0 = {busy0, done0, pass0, in1_0, in2_0, err0, ff0, fv0};
  assign obs1 = {busy1, done1, pass1, in1_1, in2_1, err1, ff1, fv1};
  assign obs  = sel ? obs1 : obs0;

  gate_bist_ctrl #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .truth(truth), .dut_out(dut_out0),
    .dut_in1(in1_0), .dut_in2(in2_0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail(ff0), .fail_valid(fv0)
  );

  gate_bist_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .truth(truth), .dut_out(dut_out1),
    .dut_in1(in1_1), .dut_in2(in2_1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail(ff1), .fail_valid(fv1)
  );

  // Expected observation c cycles after start was accepted: vector v occupies
  // s+1 cycles, results cover the vectors whose sample cycle has completed.
  function automatic logic [10:0] expect_at(input logic [3:0] tr, input logic [3:0] gt,
                                            input int s, input int c, input int rst_c);
    logic [3:0] wrong;
    int n, completed, errs, first;
    logic b, d, p;
    logic [1:0] vin;
    if (rst_c > 0 && c > rst_c) return 11'd0;
    wrong = tr ^ gt;
    n = 4 * (s + 1);
    if (c <= n) begin
      completed = (c - 1) / (s + 1);
      b = 1'b1;
      d = 1'b0;
      vin = 2'(completed);
    end else begin
      completed = 4;
      b = 1'b0;
      d = (c == n + 1);
      vin = 2'd0;
    end
    errs = 0;
    first = -1;
    for (int i = 0; i < completed; i++) begin
      if (wrong[i]) begin
        errs++;
        if (first < 0) first = i;
      end
    end
    p = (c > n) && (errs == 0);
    return {b, d, p, vin, 3'(errs), (first < 0) ? 2'd0 : 2'(first), errs != 0};
  endfunction

  // Accept a start at cycle T, then compare every cycle through one idle cycle
  // after DONE. poke_c re-pulses start with a changed truth; rst_c asserts reset.
  task automatic run_check(input string name, input logic [3:0] tr, input logic [3:0] gt,
                           input logic use_s1, input int poke_c, input int rst_c);
    int s;
    int total;
    logic [10:0] exp;
    s = use_s1 ? 1 : 2;
    total = 4 * (s + 1) + 2;
    @(posedge clk); #1;
    sel = use_s1;
    start = 1'b1;
    truth = tr;
    gate_tbl = gt;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;
      if (c == poke_c) begin
        start = 1'b1;
        truth = ~tr;
      end
      if (c == rst_c) rst = 1'b1;
      @(negedge clk);
      exp = expect_at(tr, gt, s, c, rst_c);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL %s cycle T+%0d: got {busy,done,pass,in,err,ff,fv}=%b want %b",
                 name, c, obs, exp);
      end
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    truth = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (obs0 !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_s2: got %b want %b", obs0, 11'd0);
    end
    vectors++;
    if (obs1 !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_s1: got %b want %b", obs1, 11'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_nor_pass();
    run_check("nor_pass", 4'b0001, 4'b0001, 1'b0, 0, 0);
  endtask

  task automatic test_stuck_faults();
    run_check("stuck0", 4'b0001, 4'b0000, 1'b0, 0, 0);
    run_check("stuck1", 4'b0001, 4'b1111, 1'b0, 0, 0);
  endtask

  task automatic test_ignore_start();
    run_check("ignore_start", 4'b0001, 4'b0011, 1'b0, 5, 0);
  endtask

  task automatic test_reset_midrun();
    run_check("rst_midrun", 4'b0001, 4'b0000, 1'b0, 0, 7);
    run_check("after_rst", 4'b0001, 4'b0001, 1'b0, 0, 0);
  endtask

  task automatic test_and_settle1();
    run_check("and_s1", 4'b1000, 4'b1000, 1'b1, 0, 0);
    run_check("and_s1_all_wrong", 4'b1000, 4'b0111, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_check("b2b_a", 4'b0110, 4'b0010, 1'b0, 0, 0);
    run_check("b2b_b", 4'b0110, 4'b0110, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_check("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_stuck_faults();
    test_ignore_start();
    test_reset_midrun();
    test_and_settle1();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
